// File: rtl/mojo_serial_pkg.sv
// ---------------------------------------------------------------------------
// mojo_serial_pkg
// Shared definitions for the serial line assembler: the two ASCII control
// characters that frame a line, the line-assembly FSM state type and a small
// classifier for payload bytes.
// ---------------------------------------------------------------------------
package mojo_serial_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    DONE    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  // A payload byte is anything that is neither a line terminator nor a CR.
  function automatic logic is_payload(input logic [7:0] b);
    return (b != ASCII_CR) && (b != ASCII_LF);
  endfunction

endpackage

// File: rtl/mojo_serial_line_in_if.sv
// ---------------------------------------------------------------------------
// mojo_serial_line_in_if
// Bundles the byte-stream input, the assembled-line output with its
// valid/ack handshake, and the three event pulses.
//   master : byte source + line consumer (drives rx_data, new_rx_data, line_ack)
//   slave  : the line assembler (drives line, line_len, line_valid, pulses)
// Signals:
//   rx_data[7:0]          received byte
//   new_rx_data           one-cycle strobe, rx_data valid this cycle
//   line[8*MAX_BYTES-1:0] payload, first byte in the top byte lane
//   line_len              payload byte count
//   line_valid            line/line_len complete and stable
//   line_ack              consumer has taken the line
//   overflow/timeout/dropped  one-cycle event pulses
// ---------------------------------------------------------------------------
interface mojo_serial_line_in_if #(
  parameter int MAX_BYTES = 40
);
  localparam int LEN_W = $clog2(MAX_BYTES + 1);

  logic [7:0]             rx_data;
  logic                   new_rx_data;
  logic [8*MAX_BYTES-1:0] line;
  logic [LEN_W-1:0]       line_len;
  logic                   line_valid;
  logic                   line_ack;
  logic                   overflow;
  logic                   timeout;
  logic                   dropped;

  modport master (
    output rx_data, new_rx_data, line_ack,
    input  line, line_len, line_valid, overflow, timeout, dropped
  );

  modport slave (
    input  rx_data, new_rx_data, line_ack,
    output line, line_len, line_valid, overflow, timeout, dropped
  );

endinterface

// File: rtl/mojo_idle_timer.sv
// ---------------------------------------------------------------------------
// mojo_idle_timer
// Saturating idle-cycle counter. Counts enabled cycles since the last clear
// and flags expiry once it has counted TIMEOUT_CYCLES-1 idle cycles.
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous active-high reset
//   clear   synchronous clear (wins over enable)
//   enable  count this cycle
//   expired count has reached TIMEOUT_CYCLES-1 while enabled
// ---------------------------------------------------------------------------
module mojo_idle_timer #(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  // Idle counter: clear has priority, then saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (clear) begin
      r_count <= {CNT_W{1'b0}};
    end else if (enable && (r_count != CNT_LAST)) begin
      r_count <= r_count + CNT_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign expired = enable && (r_count == CNT_LAST);

endmodule

// File: rtl/mojo_serial_line_in.sv
// ---------------------------------------------------------------------------
// mojo_serial_line_in
// Assembles LF-terminated lines from a byte stream (CR ignored) into a
// wide register and hands them to a consumer with a valid/ack handshake.
// Over-long lines are discarded up to the next LF, and partial lines are
// abandoned after TIMEOUT_CYCLES idle cycles.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  mojo_serial_line_in_if.slave (byte input, line output, pulses)
// ---------------------------------------------------------------------------
module mojo_serial_line_in #(
  parameter int MAX_BYTES      = 40,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst,
  mojo_serial_line_in_if.slave  bus
);

  import mojo_serial_pkg::*;

  localparam int               LINE_W  = 8 * MAX_BYTES;
  localparam int               LEN_W   = $clog2(MAX_BYTES + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t            r_state;
  logic [LINE_W-1:0] r_line;
  logic [LEN_W-1:0]  r_len;
  logic              r_valid;
  logic              r_overflow;
  logic              r_timeout;
  logic              r_dropped;

  logic w_strobe_active;  // any strobe except CR
  logic w_strobe_data;    // payload byte strobe
  logic w_strobe_lf;      // line terminator strobe
  logic w_timer_en;
  logic w_timer_clear;
  logic w_expired;

  assign w_strobe_active = bus.new_rx_data && (bus.rx_data != ASCII_CR);
  assign w_strobe_data   = bus.new_rx_data && is_payload(bus.rx_data);
  assign w_strobe_lf     = bus.new_rx_data && (bus.rx_data == ASCII_LF);

  // The timer only runs while a line is partially received; elsewhere it is
  // held at zero so every new line starts with a full idle budget.
  assign w_timer_en    = (r_state == FILL) || (r_state == DISCARD);
  assign w_timer_clear = w_strobe_active || !w_timer_en;

  mojo_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_timer_clear),
    .enable  (w_timer_en),
    .expired (w_expired)
  );

  // Line-assembly FSM with registered buffer, length, valid and pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_line     <= {LINE_W{1'b0}};
      r_len      <= {LEN_W{1'b0}};
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
      r_dropped  <= 1'b0;
      case (r_state)
        IDLE: begin
          // Stray LFs here are empty lines and are swallowed.
          if (w_strobe_data) begin
            r_line                <= {LINE_W{1'b0}};
            r_line[LINE_W-1 -: 8] <= bus.rx_data;
            r_len                 <= LEN_ONE;
            r_state               <= FILL;
          end
        end
        FILL: begin
          // A byte arriving on the expiry cycle is served first.
          if (w_strobe_data) begin
            if (r_len == LEN_MAX) begin
              r_overflow <= 1'b1;
              r_line     <= {LINE_W{1'b0}};
              r_len      <= {LEN_W{1'b0}};
              r_state    <= DISCARD;
            end else begin
              for (int i = 0; i < MAX_BYTES; i++) begin
                if (r_len == LEN_W'(i)) begin
                  r_line[LINE_W-1-8*i -: 8] <= bus.rx_data;
                end
              end
              r_len <= r_len + LEN_ONE;
            end
          end else if (w_strobe_lf) begin
            r_valid <= 1'b1;
            r_state <= DONE;
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_line    <= {LINE_W{1'b0}};
            r_len     <= {LEN_W{1'b0}};
            r_state   <= IDLE;
          end else begin
            r_state <= FILL;
          end
        end
        DONE: begin
          // No back-pressure exists, so bytes during a pending line are lost.
          if (w_strobe_active) begin
            r_dropped <= 1'b1;
          end
          if (bus.line_ack) begin
            r_valid <= 1'b0;
            r_line  <= {LINE_W{1'b0}};
            r_len   <= {LEN_W{1'b0}};
            r_state <= IDLE;
          end
        end
        DISCARD: begin
          // Timeout here returns silently: the overflow was already reported.
          if (w_strobe_lf) begin
            r_state <= IDLE;
          end else if (w_expired && !w_strobe_data) begin
            r_state <= IDLE;
          end else begin
            r_state <= DISCARD;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_line  <= {LINE_W{1'b0}};
          r_len   <= {LEN_W{1'b0}};
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.line       = r_line;
  assign bus.line_len   = r_len;
  assign bus.line_valid = r_valid;
  assign bus.overflow   = r_overflow;
  assign bus.timeout    = r_timeout;
  assign bus.dropped    = r_dropped;

endmodule

// File: doc/mojo_serial_line_in.md
MOJO_SERIAL_LINE_IN -- requirements
Module: mojo_serial_line_in

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 40: maximum payload bytes per line (1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 500000: idle clk cycles (10 ms at 50 MHz) that abort a partial line (>=2).
REQ-003 SHALL have port clk  input  1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port rx_data  input  8: received byte from the AVR serial interface.
REQ-006 SHALL have port new_rx_data  input  1: one-cycle strobe; rx_data is valid in that cycle.
REQ-007 SHALL have port line  output  8*MAX_BYTES: assembled payload; first byte in bits [8*MAX_BYTES-1 -: 8]; unused trailing bytes are zero.
REQ-008 SHALL have port line_len  output  $clog2(MAX_BYTES+1): payload byte count.
REQ-009 SHALL have port line_valid  output  1: level; line and line_len are stable and complete.
REQ-010 SHALL have port line_ack  input  1: consumer has taken the line; meaningful only while line_valid=1.
REQ-011 SHALL have port overflow  output  1: one-cycle pulse when a line exceeds MAX_BYTES.
REQ-012 SHALL have port timeout  output  1: one-cycle pulse when a partial line is aborted for idleness.
REQ-013 SHALL have port dropped  output  1: one-cycle pulse when a byte arrives while line_valid=1.

Function
REQ-014 SHALL implement FSM states IDLE, FILL, DONE, DISCARD.
REQ-015 SHALL ignore CR (8'h0D) in every state, with no effect on the timeout counter.
REQ-016 In IDLE, SHALL ignore LF (8'h0A), so empty lines produce no output.
REQ-017 In IDLE, any other byte SHALL be stored at index 0, set count=1, and move to FILL.
REQ-018 In FILL, a non-CR/LF byte with count<MAX_BYTES SHALL be stored at index count, and count SHALL increment.
REQ-019 In FILL, a non-CR/LF byte with count==MAX_BYTES SHALL pulse overflow, clear the buffer and count, and move to DISCARD.
REQ-020 In FILL, LF SHALL move to DONE; line_valid SHALL rise on the cycle after the LF strobe.
REQ-021 In DONE, line, line_len and line_valid SHALL hold until line_ack=1.
REQ-022 The cycle after line_ack is sampled, the FSM SHALL be in IDLE with line_valid=0, line all zero and line_len=0.
REQ-023 In DONE, new_rx_data SHALL pulse dropped and discard the byte; this includes the cycle in which line_ack is high.
REQ-024 In DISCARD, all bytes except LF SHALL be discarded; LF SHALL return the FSM to IDLE with no output.
REQ-025 An idle counter SHALL clear on every non-CR strobe and increment otherwise while in FILL or DISCARD.
REQ-026 When the idle counter reaches TIMEOUT_CYCLES-1, the block SHALL pulse timeout (FILL only), clear the buffer and count, and go to IDLE.
REQ-027 A strobe in the same cycle as timeout expiry SHALL take priority: the byte is processed and the counter clears.
REQ-028 The idle counter SHALL saturate and never wrap; in IDLE and DONE it SHALL be held at 0.
REQ-029 The block SHALL accept one byte per clk cycle; there is no back-pressure to the source.

Reset
REQ-030 Reset SHALL asynchronously force: state=IDLE, line=0, line_len=0, line_valid=0, overflow=0, timeout=0, dropped=0, idle counter=0.
REQ-031 Reset asserted mid-line or in DONE SHALL discard all content with no output pulse.

Structure
REQ-032 Package mojo_serial_pkg SHALL hold ASCII_CR, ASCII_LF and the FSM state type.
REQ-033 The idle counter SHALL be sub-module mojo_idle_timer, with ports clk, rst, clear, enable, expired and parameter TIMEOUT_CYCLES.
REQ-034 Buffer writes SHALL be byte-indexed into a single 8*MAX_BYTES register; no RAM.

Verification (MAX_BYTES=4, TIMEOUT_CYCLES=20)
REQ-035 Bytes "AB\r\n" -> line_valid=1 one cycle after LF; line=32'h41420000; line_len=2; holds until ack; zeros the cycle after ack.
REQ-036 Bytes "ABCDE\n" -> overflow pulse at 'E'; no line_valid; then "Z\n" -> line=32'h5A000000, line_len=1.
REQ-037 Byte "A", then 19 idle cycles -> timeout pulse exactly once; then "Q\n" -> line_len=1, first byte 8'h51.
REQ-038 Line pending, then byte 'X' in the same cycle as line_ack -> dropped pulse; next line excludes 'X'.
REQ-039 "\n\r\n" in IDLE -> no output, no pulses.
REQ-040 rst asserted after "AB" -> all outputs 0 immediately; after release, "C\n" -> line_len=1.
